// File: rtl/io_request_bridge.sv
// io_request_bridge: turns CPU valid/ready requests into the IO block's single-cycle
// strobe interface, with credit-limited, in-order read responses.
module io_request_bridge #(
  parameter int REQ_DEPTH    = 4,
  parameter int RESP_DEPTH   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic        main_clk,
  input  logic        main_reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_address,
  input  logic [15:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [31:0] address_io,
  output logic [15:0] data_in_io,
  output logic [1:0]  control_io,
  input  logic [15:0] data_out_io,
  output logic        busy
);

  localparam int QAW = $clog2(REQ_DEPTH);
  localparam int RAW = $clog2(RESP_DEPTH);
  localparam int QCW = QAW + 1;
  localparam int RCW = RAW + 1;
  localparam int PD  = READ_LATENCY + 1;
  localparam int EW  = 50;

  logic [EW-1:0]  req_mem [REQ_DEPTH];
  logic [QAW-1:0] req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  logic [QCW-1:0] req_cnt_q, req_cnt_d;
  logic           req_push, req_empty;
  logic [EW-1:0]  req_head;
  logic           head_write, head_byte;
  logic [31:0]    head_addr;
  logic [15:0]    head_data;

  logic           issue, issue_read, credit_ok;
  logic [RCW:0]   credit_sum;
  logic           issue_valid_q, issue_valid_d;
  logic [31:0]    address_q, address_d;
  logic [15:0]    data_in_q, data_in_d;
  logic [1:0]     control_q, control_d;

  logic [PD-1:0]  pipe_vld_q, pipe_vld_d, pipe_byte_q, pipe_byte_d;
  logic [RCW-1:0] inflight_q, inflight_d;
  logic           capture;
  logic [15:0]    capture_data;

  logic [15:0]    resp_mem [RESP_DEPTH];
  logic [RAW-1:0] resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
  logic [RCW-1:0] resp_cnt_q, resp_cnt_d;
  logic           resp_pop;

  assign req_empty = (req_cnt_q == '0);
  assign req_ready = (req_cnt_q != QCW'(REQ_DEPTH));
  assign req_push  = req_valid && req_ready;
  assign req_head  = req_mem[req_rd_q];
  assign {head_write, head_byte, head_addr, head_data} = req_head;

  // A read may only issue if a response slot is guaranteed for it.
  assign credit_sum = {1'b0, inflight_q} + {1'b0, resp_cnt_q};
  assign credit_ok  = credit_sum < (RCW+1)'(RESP_DEPTH);
  assign issue      = !req_empty && (head_write || credit_ok);
  assign issue_read = issue && !head_write;

  assign capture      = pipe_vld_q[PD-1];
  assign capture_data = pipe_byte_q[PD-1] ? {8'h00, data_out_io[7:0]} : data_out_io;

  assign resp_valid = (resp_cnt_q != '0);
  assign resp_pop   = resp_valid && resp_ready;
  assign resp_data  = resp_valid ? resp_mem[resp_rd_q] : '0;

  assign address_io = address_q;
  assign data_in_io = data_in_q;
  assign control_io = control_q;
  assign busy       = !req_empty || issue_valid_q || (|pipe_vld_q) || resp_valid;

  always_comb begin
    req_wr_d      = req_wr_q + QAW'(req_push);
    req_rd_d      = req_rd_q + QAW'(issue);
    req_cnt_d     = req_cnt_q + QCW'(req_push) - QCW'(issue);
    issue_valid_d = issue;
    address_d     = issue ? head_addr : address_q;
    data_in_d     = issue ? head_data : data_in_q;
    control_d     = issue ? {head_write, head_byte} : 2'b00;
    pipe_vld_d    = pipe_vld_q;
    pipe_byte_d   = pipe_byte_q;
    pipe_vld_d[0]  = issue_read;
    pipe_byte_d[0] = head_byte;
    for (int i = 1; i < PD; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_byte_d[i] = pipe_byte_q[i-1];
    end
    inflight_d = inflight_q + RCW'(issue_read) - RCW'(capture);
    resp_wr_d  = resp_wr_q + RAW'(capture);
    resp_rd_d  = resp_rd_q + RAW'(resp_pop);
    resp_cnt_d = resp_cnt_q + RCW'(capture) - RCW'(resp_pop);
  end

  always_ff @(posedge main_clk or negedge main_reset_n) begin
    if (!main_reset_n) begin
      req_wr_q      <= '0;
      req_rd_q      <= '0;
      req_cnt_q     <= '0;
      issue_valid_q <= 1'b0;
      address_q     <= '0;
      data_in_q     <= '0;
      control_q     <= 2'b00;
      pipe_vld_q    <= '0;
      pipe_byte_q   <= '0;
      inflight_q    <= '0;
      resp_wr_q     <= '0;
      resp_rd_q     <= '0;
      resp_cnt_q    <= '0;
    end else begin
      req_wr_q      <= req_wr_d;
      req_rd_q      <= req_rd_d;
      req_cnt_q     <= req_cnt_d;
      issue_valid_q <= issue_valid_d;
      address_q     <= address_d;
      data_in_q     <= data_in_d;
      control_q     <= control_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_byte_q   <= pipe_byte_d;
      inflight_q    <= inflight_d;
      resp_wr_q     <= resp_wr_d;
      resp_rd_q     <= resp_rd_d;
      resp_cnt_q    <= resp_cnt_d;
    end
  end

  // Storage arrays carry no reset; occupancy counters gate every read of them.
  always_ff @(posedge main_clk) begin
    if (req_push) begin
      req_mem[req_wr_q] <= {req_write, req_byte, req_address, req_data};
    end
    if (capture) begin
      resp_mem[resp_wr_q] <= capture_data;
    end
  end

  assert property (@(posedge main_clk) disable iff (!main_reset_n)
    !(capture && !resp_pop && (resp_cnt_q == RCW'(RESP_DEPTH))));

endmodule

// File: tb/tb_io_request_bridge.sv
// Directed bench for io_request_bridge with a two-stage registered IO block model.
module tb_io_request_bridge;

  logic        main_clk;
  logic        main_reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [31:0] req_address;
  logic [15:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [31:0] address_io;
  logic [15:0] data_in_io;
  logic [1:0]  control_io;
  logic [15:0] data_out_io;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  logic [31:0] issued_q [$];
  logic [15:0] exp_q [$];
  logic [15:0] io_stage1;

  io_request_bridge #(
    .REQ_DEPTH(4), .RESP_DEPTH(4), .READ_LATENCY(2)
  ) dut (
    .main_clk(main_clk), .main_reset_n(main_reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .address_io(address_io), .data_in_io(data_in_io), .control_io(control_io),
    .data_out_io(data_out_io), .busy(busy)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  function automatic logic [15:0] io_model(input logic [31:0] a);
    if (a == 32'h8100_0002) return 16'h1234;
    return a[15:0] ^ 16'h5A00;
  endfunction

  function automatic logic [15:0] expect_rd(input logic b, input logic [31:0] a);
    logic [15:0] m;
    m = io_model(a);
    return b ? {8'h00, m[7:0]} : m;
  endfunction

  // IO block: data_out_io is valid two edges after address_io is driven
  always @(posedge main_clk) begin
    io_stage1   <= io_model(address_io);
    data_out_io <= io_stage1;
  end

  always @(negedge main_clk) begin
    if (control_io != 2'b00) begin
      issue_cnt <= issue_cnt + 1;
      issued_q.push_back(address_io);
    end
  end

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic w, input logic b, input logic [31:0] a, input logic [15:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_byte = b; req_address = a; req_data = d;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      check("push_ready", {31'b0, req_ready}, 32'd1);
    end else begin
      tick();
      if (!w) exp_q.push_back(expect_rd(b, a));
      $display("push %s byte=%0d addr=%h data=%h", w ? "write" : "read ", b, a, d);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    logic [15:0] e;
    n = 0;
    resp_ready = 1'b1;
    while (exp_q.size() > 0 && n < max_cycles) begin
      if (resp_valid) begin
        e = exp_q.pop_front();
        $display("resp data=%h", resp_data);
        check("resp_data", {16'b0, resp_data}, {16'b0, e});
      end
      tick();
      n++;
    end
    resp_ready = 1'b0;
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int seen;
    logic [15:0] e;
    main_reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_address = '0; req_data = '0; resp_ready = 1'b0;
    repeat (2) @(posedge main_clk);
    #1;
    check("rst_req_ready",  {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_data",  {16'b0, resp_data}, 32'd0);
    check("rst_address",    address_io, 32'd0);
    check("rst_data_in",    {16'b0, data_in_io}, 32'd0);
    check("rst_control",    {30'b0, control_io}, 32'd0);
    check("rst_busy",       {31'b0, busy}, 32'd0);
    main_reset_n = 1'b1;
    tick();

    // single word read
    push(1'b0, 1'b0, 32'h8100_0002, 16'h0000);
    check("t1_busy", {31'b0, busy}, 32'd1);
    tick();
    check("t1_addr", address_io, 32'h8100_0002);
    check("t1_ctl",  {30'b0, control_io}, 32'd0);
    tick(); tick();
    check("t1_early", {31'b0, resp_valid}, 32'd0);
    tick();
    check("t1_valid", {31'b0, resp_valid}, 32'd1);
    check("t1_data",  {16'b0, resp_data}, 32'h0000_1234);
    e = exp_q.pop_front();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("t1_popped", {31'b0, resp_valid}, 32'd0);
    check("t1_idle",   {31'b0, busy}, 32'd0);

    // byte write strobe
    base = issue_cnt;
    push(1'b1, 1'b1, 32'h8000_0003, 16'h0001);
    tick();
    check("t2_ctl",  {30'b0, control_io}, 32'd3);
    check("t2_data", {16'b0, data_in_io}, 32'h0000_0001);
    check("t2_addr", address_io, 32'h8000_0003);
    tick();
    check("t2_ctl_drop", {30'b0, control_io}, 32'd0);
    seen = 0;
    repeat (6) begin
      if (resp_valid) seen++;
      tick();
    end
    check("t2_no_resp", seen, 32'd0);
    check("t2_one_issue", issue_cnt - base, 32'd1);
    check("t2_idle", {31'b0, busy}, 32'd0);

    // credit stall: six byte reads, consumer stalled
    base = issue_cnt;
    issued_q.delete();
    for (int i = 0; i < 6; i++) push(1'b0, 1'b1, 32'h8100_0010 + i, 16'h0000);
    repeat (8) tick();
    check("t3_issued",    issue_cnt - base, 32'd4);
    check("t3_ctl_idle",  {30'b0, control_io}, 32'd0);
    check("t3_valid",     {31'b0, resp_valid}, 32'd1);
    check("t3_head",      {16'b0, resp_data}, 32'h0000_0010);
    check("t3_req_ready", {31'b0, req_ready}, 32'd1);
    drain(80);
    check("t3_issued_all", issue_cnt - base, 32'd6);
    for (int i = 0; i < 6; i++) check("t3_order", issued_q[i], 32'h8100_0010 + i);
    check("t3_idle", {31'b0, busy}, 32'd0);

    // request FIFO fills while credits are exhausted
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 32'h8100_0020 + i, 16'h0000);
    repeat (8) tick();
    check("t4_ready_pre", {31'b0, req_ready}, 32'd1);
    for (int i = 4; i < 8; i++) push(1'b0, 1'b1, 32'h8100_0020 + i, 16'h0000);
    check("t4_full", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b1; req_address = 32'h8100_0028;
    repeat (3) tick();
    check("t4_held", {31'b0, req_ready}, 32'd0);
    check("t4_head", {16'b0, resp_data}, 32'h0000_0020);
    e = exp_q.pop_front();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("t4_still_full", {31'b0, req_ready}, 32'd0);
    tick();
    check("t4_freed", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    exp_q.push_back(expect_rd(1'b1, 32'h8100_0028));
    $display("push read  byte=1 addr=81000028 data=0000");
    drain(100);
    check("t4_idle", {31'b0, busy}, 32'd0);

    // mixed read / write / read order
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_address = 32'h8100_0030; req_data = 16'h0000;
    tick();
    exp_q.push_back(expect_rd(1'b0, 32'h8100_0030));
    $display("push read  byte=0 addr=81000030 data=0000");
    req_write = 1'b1; req_byte = 1'b0; req_address = 32'h8000_0040; req_data = 16'hBEEF;
    tick();
    $display("push write byte=0 addr=80000040 data=beef");
    check("t5_a_addr", address_io, 32'h8100_0030);
    check("t5_a_ctl",  {30'b0, control_io}, 32'd0);
    req_write = 1'b0; req_byte = 1'b1; req_address = 32'h8100_0031; req_data = 16'h0000;
    tick();
    exp_q.push_back(expect_rd(1'b1, 32'h8100_0031));
    $display("push read  byte=1 addr=81000031 data=0000");
    check("t5_b_addr", address_io, 32'h8000_0040);
    check("t5_b_ctl",  {30'b0, control_io}, 32'd2);
    check("t5_b_data", {16'b0, data_in_io}, 32'h0000_BEEF);
    req_valid = 1'b0;
    tick();
    check("t5_c_addr", address_io, 32'h8100_0031);
    check("t5_c_ctl",  {30'b0, control_io}, 32'd1);
    drain(40);

    // reset with reads in flight and a response unread
    push(1'b0, 1'b0, 32'h8100_0050, 16'h0000);
    repeat (4) tick();
    check("t6_resp", {31'b0, resp_valid}, 32'd1);
    push(1'b0, 1'b0, 32'h8100_0051, 16'h0000);
    push(1'b0, 1'b0, 32'h8100_0052, 16'h0000);
    tick();
    check("t6_busy_pre", {31'b0, busy}, 32'd1);
    main_reset_n = 1'b0;
    #1;
    check("t6_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("t6_resp_data",  {16'b0, resp_data}, 32'd0);
    check("t6_control",    {30'b0, control_io}, 32'd0);
    check("t6_address",    address_io, 32'd0);
    check("t6_busy",       {31'b0, busy}, 32'd0);
    check("t6_req_ready",  {31'b0, req_ready}, 32'd1);
    exp_q.delete();
    tick(); tick();
    main_reset_n = 1'b1;
    resp_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      if (resp_valid) seen++;
      tick();
    end
    resp_ready = 1'b0;
    check("t6_no_stale", seen, 32'd0);
    check("t6_idle", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_request_bridge.md
Name: io_request_bridge

Overview:
- Sits directly upstream of the memory-mapped IO block and drives its address_io / data_in_io / control_io inputs; consumes its data_out_io.
- Converts the CPU side's valid/ready request and response handshakes into the IO block's one-cycle-strobe, fixed-latency protocol.
- Buffers requests, keeps reads in order, and tracks in-flight reads so read data is never dropped when the response consumer stalls.

Parameters:
REQ_DEPTH, 4, request FIFO entries (power of 2, >=2)
RESP_DEPTH, 4, read-response FIFO entries (power of 2, >=2)
READ_LATENCY, 2, edges from IO-side drive until data_out_io is valid

Ports:
main_clk  input  1  sole clock
main_reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request offered
req_ready  output  1  request FIFO not full
req_write  input  1  1=write, 0=read
req_byte  input  1  1=byte access, 0=word
req_address  input  32  IO address; bit31 must be 1
req_data  input  16  write data
resp_valid  output  1  read data available
resp_ready  input  1  consumer takes read data
resp_data  output  16  read data, zero-extended for byte reads
address_io  output  32  to IO block
data_in_io  output  16  to IO block
control_io  output  2  to IO block, {write_strobe, byte}
data_out_io  input  16  from IO block
busy  output  1  any request queued, in flight, or response unread

Behaviour:
- Reset (async, main_reset_n=0):
  - Both FIFOs empty; in-flight pipe cleared; issue register invalid.
  - Outputs: req_ready=1, resp_valid=0, resp_data=0, address_io=0, data_in_io=0, control_io=2'b00, busy=0.
  - Reset mid-operation discards all queued, in-flight and unread data. No strobe may glitch high.
- Request FIFO:
  - Push on req_valid&&req_ready, storing {write, byte, address, data}.
  - req_ready = !full. It does not depend on a same-cycle pop (no bypass).
  - Pointers wrap modulo REQ_DEPTH.
- Issue rule, evaluated each cycle:
  - The head pops into the registered issue stage if the FIFO is non-empty and either the head is a write, or (reads_in_flight + resp_count) < RESP_DEPTH.
  - At most one issue per cycle; back-to-back issues are allowed.
- IO-side outputs are registered from the issue stage and valid for exactly one cycle per request:
  - address_io = address.
  - data_in_io = data (raw; the IO block handles byte lane duplication).
  - control_io = {write, byte}.
  - Cycles with no issue: control_io=2'b00; address_io and data_in_io hold their last value.
  - Consequence: control_io[1] is a single-cycle write strobe, never held.
- Read tracking:
  - An issued read enters a READ_LATENCY+1 deep valid shift pipe.
  - When the tag exits, data_out_io is captured into the response FIFO.
  - Zero-latency path: push at E0 → issue register loaded at E1 → IO outputs driven after E1 → data_out_io valid after E1+READ_LATENCY → captured at E1+READ_LATENCY+1. resp_valid is therefore high 4 edges after acceptance at default parameters.
- Writes produce no response and do not enter the response path.
- Ordering: strict program order. Reads and writes to the same device are never reordered.
- Response FIFO:
  - resp_valid = !empty; resp_data = head; pop on resp_valid&&resp_ready.
  - Simultaneous capture and pop is legal.
  - Overflow is impossible by the credit rule; assert this in simulation.
- busy = reqFIFO non-empty || issue valid || any pipe tag || respFIFO non-empty.
- Widths: reads_in_flight and resp_count are sized to hold 0..RESP_DEPTH inclusive.

Test Plan:
- Single read: push read addr 0x8100_0002 word at cycle 0; IO model returns 0x1234 → control_io=2'b00 with address for one cycle; resp_valid at edge 4 with resp_data=0x1234; busy falls after the pop.
- Write strobe: push write byte addr 0x8000_0003 data 0x0001 → exactly one cycle of control_io=2'b11 and data_in_io=0x0001; resp_valid never asserts.
- Credit stall: resp_ready=0, push 6 reads → exactly 4 issue, then control_io stays 00 and the 5th waits. Raise resp_ready → responses arrive in order, and the remaining 2 issue only as credits free.
- Full request FIFO: hold resp_ready=0 with 4 reads outstanding, push 4 more → req_ready=0 after the 4th accept. A 5th offer is not accepted until the first pop.
- Mixed order: read A, write B, read C back-to-back → IO outputs in order A, B, C on consecutive cycles; responses A then C.
- Reset mid-flight: assert main_reset_n=0 while 2 reads are in flight and 1 response is unread → immediately resp_valid=0, control_io=00, busy=0. After release, no stale response appears.
